// File: rtl/debug_probe_scanner_if.sv
// Tagged item stream from the debug probe scanner.
// master drives items, slave returns ready.
interface debug_probe_scanner_if;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [7:0]  out_index;
  logic [31:0] out_data;

  modport master (
    output out_valid,
    output out_kind,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_kind,
    input  out_index,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/debug_probe_scanner.sv
// Sweeps the cpu probe port over r0..r31 then a memory
// window, streaming one tagged item per read.
module debug_probe_scanner #(
  parameter logic [31:0] MEM_BASE  = 32'h0,
  parameter int unsigned MEM_WORDS = 8,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  rf_addr,
  output logic [31:0] mem_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  debug_probe_scanner_if.master stream
);

  localparam logic [31:0] BASE = {MEM_BASE[31:2], 2'b00};
  localparam logic [7:0]  LAST_MEM = 8'(MEM_WORDS - 1);
  localparam logic [3:0]  LAST_CNT = 4'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RF_ISSUE,
    RF_WAIT,
    RF_OUT,
    MEM_ISSUE,
    MEM_WAIT,
    MEM_OUT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  rf_addr_q, rf_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        valid_q, valid_d;
  logic        kind_q, kind_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rf_addr_d  = rf_addr_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    kind_d     = kind_q;
    index_d    = index_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RF_ISSUE;
          idx_d   = 8'd0;
          busy_d  = 1'b1;
        end
      end
      RF_ISSUE: begin
        rf_addr_d = idx_q[4:0];
        cnt_d     = 4'd0;
        state_d   = RF_WAIT;
      end
      RF_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          data_d  = rf_data;
          kind_d  = 1'b0;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = RF_OUT;
        end
      end
      RF_OUT: begin
        if (stream.out_ready) begin
          valid_d = 1'b0;
          if (idx_q == 8'd31) begin
            idx_d   = 8'd0;
            state_d = MEM_ISSUE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RF_ISSUE;
          end
        end
      end
      MEM_ISSUE: begin
        mem_addr_d = BASE + {22'd0, idx_q, 2'b00};
        cnt_d      = 4'd0;
        state_d    = MEM_WAIT;
      end
      MEM_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          data_d  = mem_data;
          kind_d  = 1'b1;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = MEM_OUT;
        end
      end
      MEM_OUT: begin
        if (stream.out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_MEM) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = MEM_ISSUE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      cnt_q      <= 4'd0;
      rf_addr_q  <= 5'd0;
      mem_addr_q <= BASE;
      valid_q    <= 1'b0;
      kind_q     <= 1'b0;
      index_q    <= 8'd0;
      data_q     <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rf_addr_q  <= rf_addr_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      kind_q     <= kind_d;
      index_q    <= index_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rf_addr          = rf_addr_q;
  assign mem_addr         = mem_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign stream.out_valid = valid_q;
  assign stream.out_kind  = kind_q;
  assign stream.out_index = index_q;
  assign stream.out_data  = data_q;

endmodule

// File: tb/tb_debug_probe_scanner.sv
// Bench for debug_probe_scanner: two instances (short window,
// READ_LAT=1; 256-word wrapping window, READ_LAT=3).
module tb_debug_probe_scanner;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        start_a, start_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic [31:0] rf_data_a, mem_data_a;
  logic [31:0] rf_data_b, mem_data_b;
  logic        busy_a, done_a, busy_b, done_b;

  debug_probe_scanner_if ifa ();
  debug_probe_scanner_if ifb ();

  debug_probe_scanner #(
    .MEM_BASE (32'h0000_0100),
    .MEM_WORDS(4),
    .READ_LAT (1)
  ) u_a (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start_a),
    .rf_addr (rf_addr_a),
    .mem_addr(mem_addr_a),
    .rf_data (rf_data_a),
    .mem_data(mem_data_a),
    .busy    (busy_a),
    .done    (done_a),
    .stream  (ifa)
  );

  debug_probe_scanner #(
    .MEM_BASE (32'hFFFF_FFFA),
    .MEM_WORDS(256),
    .READ_LAT (3)
  ) u_b (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start_b),
    .rf_addr (rf_addr_b),
    .mem_addr(mem_addr_b),
    .rf_data (rf_data_b),
    .mem_data(mem_data_b),
    .busy    (busy_b),
    .done    (done_b),
    .stream  (ifb)
  );

  // cpu A: data follows the address immediately
  assign rf_data_a  = 32'hA000_0000 | {27'd0, rf_addr_a};
  assign mem_data_a = mem_addr_a + 32'd1;

  // cpu B: data is stale until the 3rd cycle after an address change
  int          rf_age_b = 100;
  int          mem_age_b = 100;
  logic [4:0]  rf_seen_b = 5'd0;
  logic [31:0] mem_seen_b = 32'hFFFF_FFF8;

  always @(negedge clk) begin
    if (rf_addr_b !== rf_seen_b) begin
      rf_seen_b = rf_addr_b;
      rf_age_b  = 0;
    end else if (rf_age_b < 100) begin
      rf_age_b++;
    end
    if (mem_addr_b !== mem_seen_b) begin
      mem_seen_b = mem_addr_b;
      mem_age_b  = 0;
    end else if (mem_age_b < 100) begin
      mem_age_b++;
    end
  end

  assign rf_data_b = (rf_age_b < 2) ? 32'hDEAD_BEEF
                   : (32'hB000_0000 | {27'd0, rf_addr_b});
  assign mem_data_b = (mem_age_b < 2) ? 32'hDEAD_BEEF
                    : ~mem_addr_b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input bit b);
    return b ? 32'hFFFF_FFF8 : 32'h0000_0100;
  endfunction

  // n-th item of a sweep: {kind, index, data}
  function automatic logic [40:0] exp_item(input bit b, input int n);
    logic [31:0] a;
    if (n < 32) begin
      a = (b ? 32'hB000_0000 : 32'hA000_0000) | 32'(n);
      return {1'b0, 8'(n), a};
    end
    a = base_of(b) + 32'(4 * (n - 32));
    return {1'b1, 8'(n - 32), (b ? ~a : a + 32'd1)};
  endfunction

  function automatic logic [40:0] get_item(input bit b);
    if (b) return {ifb.out_kind, ifb.out_index, ifb.out_data};
    return {ifa.out_kind, ifa.out_index, ifa.out_data};
  endfunction

  function automatic logic get_valid(input bit b);
    return b ? ifb.out_valid : ifa.out_valid;
  endfunction

  function automatic logic [31:0] act_probe(input bit b, input logic k);
    if (k) return b ? mem_addr_b : mem_addr_a;
    return {27'd0, (b ? rf_addr_b : rf_addr_a)};
  endfunction

  function automatic logic [31:0] exp_probe(input bit b, input logic [40:0] it);
    if (it[40]) return base_of(b) + {22'd0, it[39:32], 2'b00};
    return {27'd0, it[36:32]};
  endfunction

  function automatic logic [81:0] reset_view(input bit b);
    if (b)
      return {rf_addr_b, mem_addr_b, ifb.out_valid, ifb.out_kind,
              ifb.out_index, ifb.out_data, busy_b, done_b};
    return {rf_addr_a, mem_addr_a, ifa.out_valid, ifa.out_kind,
            ifa.out_index, ifa.out_data, busy_a, done_a};
  endfunction

  function automatic logic [81:0] reset_exp(input bit b);
    return {5'd0, base_of(b), 1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0};
  endfunction

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else start_a = v;
  endtask

  task automatic set_ready(input bit b, input logic v);
    if (b) ifb.out_ready = v;
    else ifa.out_ready = v;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall r5 for 7 cycles
  task automatic run_sweep(input bit b, input int mode, input int lat);
    int n = b ? 32 + 256 : 32 + 4;
    int k = 0;
    int cyc = 0;
    int last_hs = 0;
    int stall_n = 0;
    bit dseen = 0;
    bit stalled = 0;
    logic rdy;
    logic [40:0] cur;
    logic [40:0] prev = '0;
    set_ready(b, 1'b0);
    @(negedge clk);
    set_start(b, 1'b1);
    @(negedge clk);
    set_start(b, 1'b0);
    chk("busy_after_start", b ? busy_b : busy_a, 1'b1);
    while (!dseen && cyc < 5000) begin
      cur = get_item(b);
      if (stalled) chk("stall_hold", cur, prev);
      if (b ? done_b : done_a) begin
        dseen = 1;
        chk("done_after_last", k, n);
      end
      if (get_valid(b))
        chk("probe_addr", act_probe(b, cur[40]), exp_probe(b, cur));
      if (mode == 0) begin
        rdy = 1'b1;
      end else if (mode == 1) begin
        rdy = ($urandom_range(0, 99) < 60);
      end else begin
        rdy = 1'b1;
        if (get_valid(b) && !cur[40] && cur[39:32] == 8'd5
            && stall_n < 7) begin
          rdy = 1'b0;
          stall_n++;
        end
      end
      set_ready(b, rdy);
      stalled = 0;
      if (get_valid(b)) begin
        if (rdy) begin
          chk($sformatf("item%0d", k), cur, exp_item(b, k));
          if (mode == 0 && k > 0)
            chk("item_spacing", cyc - last_hs, lat + 2);
          last_hs = cyc;
          k++;
        end else begin
          stalled = 1;
          prev = cur;
        end
      end
      if (cyc == 20) set_start(b, 1'b1);
      if (cyc == 21) set_start(b, 1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("sweep_done_seen", dseen, 1'b1);
    chk("item_count", k, n);
    if (mode == 2) chk("stall_cycles", stall_n, 7);
    chk("busy_done_after", {(b ? busy_b : busy_a), (b ? done_b : done_a)}, 2'b00);
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_done", {(b ? busy_b : busy_a), get_valid(b)}, 2'b00);
    end
    set_ready(b, 1'b0);
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;

    // reset values, then quiet after release
    #100;
    chk("reset_a", reset_view(0), reset_exp(0));
    chk("reset_b", reset_view(1), reset_exp(1));
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("no_item_after_reset", {ifa.out_valid, ifb.out_valid}, 2'b00);
    end

    run_sweep(0, 0, 1);
    run_sweep(0, 2, 1);
    run_sweep(0, 1, 1);
    run_sweep(1, 0, 3);
    run_sweep(1, 1, 3);

    // abort while item r12 is pending, start pulsed while busy
    ifa.out_ready = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    begin
      int w = 0;
      while (!(ifa.out_valid && ifa.out_index == 8'd12) && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("reach_r12", {ifa.out_valid, ifa.out_index}, {1'b1, 8'd12});
    end
    ifa.out_ready = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_ignored_busy",
        {busy_a, ifa.out_valid, ifa.out_index}, {1'b1, 1'b1, 8'd12});
    resetn = 1'b0;
    #1;
    chk("abort_reset_a", reset_view(0), reset_exp(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_after_abort", {busy_a, ifa.out_valid}, 2'b00);
    end
    run_sweep(0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
